// File: rtl/sao_merge_pkg.sv
// rtl/sao_merge_pkg.sv - shared types and default widths for the SAO merge-parameter store
package sao_merge_pkg;

    localparam int DEF_N_COMP       = 3;
    localparam int DEF_N_OFFSET     = 4;
    localparam int DEF_OFFSET_LEN   = 4;
    localparam int DEF_TYPE_LEN     = 3;
    localparam int DEF_AUX_LEN      = 5;
    localparam int DEF_MAX_CTU_COLS = 120;
    localparam int DEF_CTU_X_LEN    = 9;

    typedef enum logic [1:0] {
        MODE_OFF         = 2'b00,
        MODE_NEW         = 2'b01,
        MODE_MERGE_LEFT  = 2'b10,
        MODE_MERGE_UP    = 2'b11
    } wr_mode_e;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RD_ISSUE,
        ST_RD_DATA,
        ST_WR_COMMIT
    } state_e;

    // Record layout at default widths; offsets are off0 in the MSBs down to offN-1.
    typedef struct packed {
        logic [1:0]                               mode;
        logic [DEF_TYPE_LEN-1:0]                  sao_type;
        logic [DEF_AUX_LEN-1:0]                   aux;
        logic [DEF_N_OFFSET*DEF_OFFSET_LEN-1:0]   offsets;
    } sao_rec_t;

    localparam sao_rec_t SAO_REC_ZERO = '0;

endpackage

// File: rtl/sao_param_linebuf.sv
// rtl/sao_param_linebuf.sv - single-port SRAM wrapper (active-low CEN/WEN) for the upper-neighbour row
module sao_param_linebuf #(
    parameter int DEPTH = 360,
    parameter int WIDTH = 26,
    localparam int AW   = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             cen,
    input  logic             wen,
    input  logic [AW-1:0]    a,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (!cen) begin
            if (!wen) begin
                mem[a] <= d;
            end else begin
                q <= mem[a];
            end
        end
    end

endmodule

// File: rtl/sao_merge_param_store.sv
// rtl/sao_merge_param_store.sv - SAO left/upper merge-parameter store; optional SRAM parity via SAO_MERGE_PARITY_EN
module sao_merge_param_store
    import sao_merge_pkg::*;
#(
    parameter int N_COMP       = DEF_N_COMP,
    parameter int N_OFFSET     = DEF_N_OFFSET,
    parameter int OFFSET_LEN   = DEF_OFFSET_LEN,
    parameter int TYPE_LEN     = DEF_TYPE_LEN,
    parameter int AUX_LEN      = DEF_AUX_LEN,
    parameter int MAX_CTU_COLS = DEF_MAX_CTU_COLS,
    parameter int CTU_X_LEN    = DEF_CTU_X_LEN,
    localparam int PW          = 2 + TYPE_LEN + AUX_LEN + N_OFFSET*OFFSET_LEN,
    localparam int CW          = $clog2(N_COMP)
) (
    input  logic                 clk,
    input  logic                 arst_n,
    input  logic                 ctu_start,
    input  logic [CTU_X_LEN-1:0] ctu_x,
    input  logic                 left_avail,
    input  logic                 up_avail,
    input  logic                 rd_req,
    input  logic [CW-1:0]        rd_comp,
    output logic                 rd_ready,
    output logic                 rd_valid,
    output logic [PW-1:0]        rd_left,
    output logic [PW-1:0]        rd_up,
    input  logic                 wr_valid,
    output logic                 wr_ready,
    input  logic [CW-1:0]        wr_comp,
    input  logic [1:0]           wr_mode,
    input  logic [PW-1:0]        wr_param,
    output logic                 oob,
    output logic                 par_err
);

    localparam int DEPTH = N_COMP * MAX_CTU_COLS;
    localparam int AW    = $clog2(DEPTH);
`ifdef SAO_MERGE_PARITY_EN
    localparam int SW    = PW + 1;
`else
    localparam int SW    = PW;
`endif

    state_e               state_q, state_d;
    logic [CTU_X_LEN-1:0] ctu_x_q;
    logic                 left_avail_q, up_avail_q, ctu_oob_q;
    logic [CW-1:0]        comp_q;
    logic [PW-1:0]        left_reg [N_COMP];
    logic [PW-1:0]        u_reg    [N_COMP];
    logic [PW-1:0]        wdata_q, resolved, up_capture;
    logic                 sram_rd_q, par_bad;
    logic                 rd_accept, wr_accept;
    logic                 sram_cen, sram_wen;
    logic [AW-1:0]        sram_a;
    logic [SW-1:0]        sram_d, sram_q;

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // SRAM strobes come straight from state so a reset edge kills any pending access.
    always_comb begin
        state_d   = state_q;
        wr_ready  = 1'b0;
        rd_ready  = 1'b0;
        wr_accept = 1'b0;
        rd_accept = 1'b0;
        sram_cen  = 1'b1;
        sram_wen  = 1'b1;
        case (state_q)
            ST_IDLE: begin
                wr_ready = 1'b1;
                rd_ready = !wr_valid;
                if (wr_valid) begin
                    wr_accept = 1'b1;
                    state_d   = ST_WR_COMMIT;
                end else if (rd_req) begin
                    rd_accept = 1'b1;
                    state_d   = ST_RD_ISSUE;
                end
            end
            ST_RD_ISSUE: begin
                sram_cen = !(up_avail_q && !ctu_oob_q);
                state_d  = ST_RD_DATA;
            end
            ST_RD_DATA: begin
                state_d = ST_IDLE;
            end
            ST_WR_COMMIT: begin
                sram_cen = ctu_oob_q;
                sram_wen = ctu_oob_q;
                state_d  = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign sram_a = AW'(32'(comp_q) * 32'(MAX_CTU_COLS) + 32'(ctu_x_q));

    // Merges copy the source record whole, so its resolved mode travels with it.
    always_comb begin
        resolved = '0;
        case (wr_mode)
            MODE_NEW:        resolved = wr_param;
            MODE_MERGE_LEFT: resolved = left_avail_q ? left_reg[wr_comp] : '0;
            MODE_MERGE_UP:   resolved = u_reg[wr_comp];
            default:         resolved = '0;
        endcase
    end

`ifdef SAO_MERGE_PARITY_EN
    logic par_err_q;
    assign sram_d  = {^wdata_q, wdata_q};
    assign par_bad = ^sram_q;
    assign par_err = par_err_q;

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            par_err_q <= 1'b0;
        end else if (state_q == ST_RD_DATA && sram_rd_q && par_bad) begin
            par_err_q <= 1'b1;
        end
    end
`else
    assign sram_d  = wdata_q;
    assign par_bad = 1'b0;
    assign par_err = 1'b0;
`endif

    assign up_capture = (sram_rd_q && !par_bad) ? sram_q[PW-1:0] : '0;

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            ctu_x_q      <= '0;
            left_avail_q <= 1'b0;
            up_avail_q   <= 1'b0;
            ctu_oob_q    <= 1'b0;
            oob          <= 1'b0;
            comp_q       <= '0;
            wdata_q      <= '0;
            sram_rd_q    <= 1'b0;
            rd_valid     <= 1'b0;
            rd_left      <= '0;
            rd_up        <= '0;
            for (int i = 0; i < N_COMP; i++) begin
                left_reg[i] <= '0;
                u_reg[i]    <= '0;
            end
        end else begin
            if (ctu_start) begin
                ctu_x_q      <= ctu_x;
                left_avail_q <= left_avail;
                up_avail_q   <= up_avail;
                ctu_oob_q    <= 32'(ctu_x) >= 32'(MAX_CTU_COLS);
                oob          <= oob | (32'(ctu_x) >= 32'(MAX_CTU_COLS));
                for (int i = 0; i < N_COMP; i++) begin
                    u_reg[i] <= '0;
                end
            end
            if (rd_accept) begin
                comp_q <= rd_comp;
            end
            if (wr_accept) begin
                comp_q            <= wr_comp;
                left_reg[wr_comp] <= resolved;
                wdata_q           <= resolved;
            end
            sram_rd_q <= (state_q == ST_RD_ISSUE) && !sram_cen;
            rd_valid  <= (state_q == ST_RD_DATA);
            // Placed after the ctu_start clear so an in-flight capture wins for its component.
            if (state_q == ST_RD_DATA) begin
                u_reg[comp_q] <= up_capture;
                rd_up         <= up_capture;
                rd_left       <= left_avail_q ? left_reg[comp_q] : '0;
            end
        end
    end

    sao_param_linebuf #(
        .DEPTH (DEPTH),
        .WIDTH (SW)
    ) u_linebuf (
        .clk (clk),
        .cen (sram_cen),
        .wen (sram_wen),
        .a   (sram_a),
        .d   (sram_d),
        .q   (sram_q)
    );

endmodule
